dmem_sa: RTL and testbench
==========================

Name: dmem_sa

Overview:
- Parametrised successor of the direct-data-cache block: an N-way set-associative, write-back, write-allocate L1 data cache.
- Sits between the core's load/store unit and the backing memory bus.
- Handles RISC-V load/store sizes with sign or zero extension, natural-alignment checking, dirty-victim writeback and per-set round-robin replacement.

Parameters:
- LINE_W, 256, line width in bits; power of two, ≥64.
- SETS, 64, number of sets; power of two.
- WAYS, 2, associativity; 1..8.
- ADDR_W, 64, address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- clr  in  1  asynchronous, active-high reset.
- addr  in  ADDR_W  byte address of the request.
- len  in  3  RISC-V funct3 encoding. len[1:0] is size: 0=B, 1=H, 2=W, 3=D. len[2]=1 selects a zero-extended load.
- rd  in  1  load request; held until busy=0.
- wr  in  1  store request; held until busy=0.
- data_in  in  64  store data, right-aligned.
- data_out  out  64  load result, extended to 64 bits.
- busy  out  1  stall; the request is not complete while high.
- misalign  out  1  access is not naturally aligned for its size.
- b_addr  out  ADDR_W  line-aligned bus address.
- b_data_in  in  LINE_W  fill data from the bus.
- b_rd  out  1  fill request, one-cycle pulse.
- b_dv  in  1  fill data valid, one-cycle.
- b_data_out  out  LINE_W  victim line for writeback.
- b_wr  out  1  writeback strobe, one-cycle pulse. The bus accepts the line at that edge.

Behaviour:
- Address split: offset = log2(LINE_W/8) bits, index = log2(SETS) bits, tag = remaining bits.
- Reset:
  - All valid and dirty bits cleared; round-robin pointers set to 0; FSM goes to IDLE.
  - b_rd=0, b_wr=0, b_addr=0, b_data_out=0, data_out=0, busy=0, misalign=0.
  - Reset takes effect immediately (asynchronous).
- Priority: rd and wr together is treated as wr.
- misalign is combinational = (rd|wr) & (addr mod size ≠ 0). A misaligned request is dropped: no array change, no bus activity, busy=0.
- Hit path (IDLE):
  - Tag compare over all ways is combinational.
  - On a hit, busy=0 in the same cycle.
  - Load: data_out is valid combinationally, little-endian, sign-extended unless len[2]=1.
  - Store: the selected bytes are written at the rising edge and the line is marked dirty.
- Miss path (IDLE):
  - busy=1 combinationally.
  - Victim selection: lowest-index invalid way, else the way given by the set's round-robin pointer.
- FSM, states IDLE, WB, FILL_REQ, FILL_WAIT, DONE:
  - IDLE→WB on a miss with a dirty victim.
  - IDLE→FILL_REQ on a miss with a clean or invalid victim.
  - WB: b_wr=1 for one cycle, b_addr = {victim tag, index, 0}, b_data_out = victim line; then →FILL_REQ.
  - FILL_REQ: b_rd=1 for one cycle, b_addr = {addr tag, index, 0}; then →FILL_WAIT.
  - FILL_WAIT: b_rd=0; wait indefinitely. On b_dv, install the line with valid=1, dirty=0, advance the set's pointer modulo WAYS; →DONE.
  - DONE: busy=1 for one cycle; then →IDLE, where the held request now hits and completes.
- b_dv outside FILL_WAIT is ignored.
- Reset during WB, FILL_REQ or FILL_WAIT aborts the refill. After reset, the same request misses again.
- Requests that change or drop while busy=1 are a protocol violation. The current refill still completes.

Optional Feature:
- Macro: DMEM_FLUSH_EN.
- When defined:
  - Adds ports flush (in 1) and flush_done (out 1).
  - flush sampled high in IDLE with no pending request enters state FLUSH.
  - FLUSH walks every set/way in ascending order (set-major). Each dirty line gets one b_wr pulse per cycle; clean entries are skipped in one cycle each. All valid bits are then cleared.
  - flush_done pulses for one cycle at the end; busy=1 throughout.
  - flush together with rd/wr: the request is served first.
- When undefined: no flush ports and no FLUSH state.

Decomposition:
- Shared package dmem_pkg:
  - Size encodings (SZ_B/H/W/D).
  - FSM state enum.
  - Functions for offset/index/tag widths from the parameters.
  - Load extend/align function and store byte-mask function.
- Sub-module dmem_sa_way: one way's tag/valid/dirty/data arrays, with async read, tag compare and byte-masked write. Instantiated WAYS times with generate.

Test Plan:
- Bench config: LINE_W=256, SETS=64, WAYS=2; set stride is 0x800.
- Reset, then sb 0xFF @0x0 → busy, b_rd pulse with b_addr=0x0. After b_dv, busy=0. Then lb @0x0 → data_out=0xFFFFFFFFFFFFFFFF; lbu → 0xFF; no b_rd for either.
- sd 0x1122334455667788 @0x8 (hit after fill) → ld @0x8 = 0x1122334455667788; lh @0xA = 0x5566; lhu @0xE = 0x1122; lb @0xF = 0x11.
- Dirty 0x0, then read 0x800, then read 0x1000 → one b_wr with b_addr=0x0 and b_data_out[7:0]=0xFF, then b_rd with b_addr=0x1000. Next read of 0x800 hits.
- lw @0x2, sh @0x1 → misalign=1, busy=0, no bus activity, array unchanged.
- Assert clr during FILL_WAIT for 0x40 → b_rd=0 and busy=0 immediately; a later b_dv is ignored; rd @0x40 issues a fresh b_rd.
- DMEM_FLUSH_EN: after two dirty lines, pulse flush → exactly two b_wr pulses, then flush_done. Subsequent reads miss.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_sa shared types: size codes, FSM states, geometry and lane helpers.
// DMEM_FLUSH_EN adds the FLUSH state used by the optional flush walker.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    FILL_REQ,
    FILL_WAIT,
`ifdef DMEM_FLUSH_EN
    DONE,
    FLUSH
`else
    DONE
`endif
  } state_t;

  function automatic int off_w(int line_w);
    return $clog2(line_w / 8);
  endfunction

  function automatic int idx_w(int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(int addr_w, int line_w, int sets);
    return addr_w - off_w(line_w) - idx_w(sets);
  endfunction

  function automatic logic misaligned(logic [2:0] off, logic [1:0] sz);
    logic r;
    unique case (sz)
      SZ_B:    r = 1'b0;
      SZ_H:    r = off[0];
      SZ_W:    r = |off[1:0];
      default: r = |off;
    endcase
    return r;
  endfunction

  // dword is the naturally aligned doubleword holding the access
  function automatic logic [63:0] ld_ext(logic [63:0] dword,
                                         logic [2:0] off,
                                         logic [2:0] len);
    logic [63:0] s;
    logic [63:0] r;
    s = dword >> {off, 3'b000};
    unique case (len[1:0])
      SZ_B: r = len[2] ? {56'd0, s[7:0]}
                       : {{56{s[7]}}, s[7:0]};
      SZ_H: r = len[2] ? {48'd0, s[15:0]}
                       : {{48{s[15]}}, s[15:0]};
      SZ_W: r = len[2] ? {32'd0, s[31:0]}
                       : {{32{s[31]}}, s[31:0]};
      default: r = s;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] st_mask(logic [2:0] off,
                                         logic [1:0] sz);
    logic [7:0] m;
    unique case (sz)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0f;
      default: m = 8'hff;
    endcase
    return m << off;
  endfunction

  function automatic logic [63:0] st_align(logic [63:0] d,
                                           logic [2:0] off);
    return d << {off, 3'b000};
  endfunction

endpackage

// File: rtl/dmem_sa_way.sv
// One cache way: tag/valid/dirty/data arrays, async read, tag compare,
// byte-masked store and whole-line fill.
module dmem_sa_way #(
  parameter int LINE_W = 256,
  parameter int IDX_W  = 6,
  parameter int OFF_W  = 5,
  parameter int TAG_W  = 53
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  idx,
  input  logic [TAG_W-1:0]  tag,
  output logic              hit,
  output logic              vld,
  output logic              dty,
  output logic [TAG_W-1:0]  tag_q,
  output logic [LINE_W-1:0] line,
  input  logic              st_en,
  input  logic [OFF_W-1:0]  st_word,
  input  logic [7:0]        st_mask,
  input  logic [63:0]       st_data,
  input  logic              fill_en,
  input  logic [LINE_W-1:0] fill_line,
  input  logic              inv_all
);

  localparam int SETS = 1 << IDX_W;

  logic [SETS-1:0]   valid;
  logic [SETS-1:0]   dirty;
  logic [TAG_W-1:0]  tags [SETS];
  logic [LINE_W-1:0] data [SETS];

  assign vld   = valid[idx];
  assign dty   = dirty[idx];
  assign tag_q = tags[idx];
  assign line  = data[idx];
  assign hit   = vld && (tag_q == tag);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      dirty <= '0;
    end else if (inv_all) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill_en) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if (st_en) begin
      dirty[idx] <= 1'b1;
    end
  end

  // storage carries no reset; valid bits gate every use
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tags[idx] <= tag;
      data[idx] <= fill_line;
    end else if (st_en) begin
      for (int b = 0; b < LINE_W / 8; b++) begin
        if (b / 8 == int'(st_word) && st_mask[b % 8])
          data[idx][b*8 +: 8] <= st_data[(b % 8)*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_sa.sv
// N-way set-associative write-back L1 data cache with round-robin refill.
// Define DMEM_FLUSH_EN for the flush/flush_done dirty-line walker.
module dmem_sa
  import dmem_pkg::*;
#(
  parameter int LINE_W = 256,
  parameter int SETS   = 64,
  parameter int WAYS   = 2,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        len,
  input  logic              rd,
  input  logic              wr,
  input  logic [63:0]       data_in,
  output logic [63:0]       data_out,
  output logic              busy,
  output logic              misalign,
  output logic [ADDR_W-1:0] b_addr,
  input  logic [LINE_W-1:0] b_data_in,
  output logic              b_rd,
  input  logic              b_dv,
  output logic [LINE_W-1:0] b_data_out,
  output logic              b_wr
`ifdef DMEM_FLUSH_EN
  ,
  input  logic              flush,
  output logic              flush_done
`endif
);

  localparam int OFF_W = off_w(LINE_W);
  localparam int IDX_W = idx_w(SETS);
  localparam int TAG_W = tag_w(ADDR_W, LINE_W, SETS);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [TAG_W-1:0]  tag;
  logic [IDX_W-1:0]  idx;
  logic [OFF_W-1:0]  off;
  logic [OFF_W-1:0]  wsel;
  logic [IDX_W-1:0]  way_idx;

  state_t            st, nxt;
  logic [WAY_W-1:0]  vic, vic_q, hit_way;
  logic [WAY_W-1:0]  rr [SETS];
  logic [WAYS-1:0]   hits, vlds, dtys;
  logic [TAG_W-1:0]  tags [WAYS];
  logic [LINE_W-1:0] lines [WAYS];
  logic [63:0]       dword;
  logic              hit, mis, req, vic_dirty;
  logic              st_en, fill_en, inv_all, busy_c;

  assign tag  = addr[ADDR_W-1 -: TAG_W];
  assign idx  = addr[OFF_W +: IDX_W];
  assign off  = addr[OFF_W-1:0];
  assign wsel = off >> 3;

`ifdef DMEM_FLUSH_EN
  logic [IDX_W:0]   fl_set;
  logic [WAY_W-1:0] fl_way;
  logic             fl_done_c;
  assign way_idx    = (st == FLUSH) ? fl_set[IDX_W-1:0] : idx;
  assign flush_done = fl_done_c;
`else
  assign way_idx = idx;
`endif

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    dmem_sa_way #(
      .LINE_W (LINE_W),
      .IDX_W  (IDX_W),
      .OFF_W  (OFF_W),
      .TAG_W  (TAG_W)
    ) u_way (
      .clk       (clk),
      .rst       (clr),
      .idx       (way_idx),
      .tag       (tag),
      .hit       (hits[w]),
      .vld       (vlds[w]),
      .dty       (dtys[w]),
      .tag_q     (tags[w]),
      .line      (lines[w]),
      .st_en     (st_en && hit_way == WAY_W'(w)),
      .st_word   (wsel),
      .st_mask   (st_mask(addr[2:0], len[1:0])),
      .st_data   (st_align(data_in, addr[2:0])),
      .fill_en   (fill_en && vic_q == WAY_W'(w)),
      .fill_line (b_data_in),
      .inv_all   (inv_all)
    );
  end

  assign hit = |hits;
  assign mis = (rd || wr) && misaligned(addr[2:0], len[1:0]);
  assign req = (rd || wr) && !mis;

  always_comb begin
    hit_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (hits[w]) hit_way = WAY_W'(w);
  end

  // descending scan leaves the lowest invalid way selected
  always_comb begin
    vic = rr[idx];
    for (int w = WAYS - 1; w >= 0; w--)
      if (!vlds[w]) vic = WAY_W'(w);
  end

  assign vic_dirty = vlds[vic] && dtys[vic];
  assign dword     = lines[hit_way][{wsel, 6'b0} +: 64];

  assign data_out = (!clr && st == IDLE && rd && !wr && req && hit)
                    ? ld_ext(dword, addr[2:0], len) : '0;
  assign busy     = busy_c && !clr;
  assign misalign = mis && !clr;
  assign st_en    = !clr && st == IDLE && req && hit && wr;
  assign fill_en  = !clr && st == FILL_WAIT && b_dv;

  always_comb begin
    nxt        = st;
    busy_c     = 1'b0;
    b_rd       = 1'b0;
    b_wr       = 1'b0;
    b_addr     = '0;
    b_data_out = '0;
    inv_all    = 1'b0;
`ifdef DMEM_FLUSH_EN
    fl_done_c  = 1'b0;
`endif
    unique case (st)
      IDLE: begin
        if (req && !hit) begin
          busy_c = 1'b1;
          nxt    = vic_dirty ? WB : FILL_REQ;
        end
`ifdef DMEM_FLUSH_EN
        else if (flush && !(rd || wr)) begin
          nxt = FLUSH;
        end
`endif
      end
      WB: begin
        busy_c     = 1'b1;
        b_wr       = 1'b1;
        b_addr     = {tags[vic_q], idx, {OFF_W{1'b0}}};
        b_data_out = lines[vic_q];
        nxt        = FILL_REQ;
      end
      FILL_REQ: begin
        busy_c = 1'b1;
        b_rd   = 1'b1;
        b_addr = {tag, idx, {OFF_W{1'b0}}};
        nxt    = FILL_WAIT;
      end
      FILL_WAIT: begin
        busy_c = 1'b1;
        b_addr = {tag, idx, {OFF_W{1'b0}}};
        if (b_dv) nxt = DONE;
      end
      DONE: begin
        busy_c = 1'b1;
        nxt    = IDLE;
      end
`ifdef DMEM_FLUSH_EN
      FLUSH: begin
        busy_c = 1'b1;
        if (fl_set[IDX_W]) begin
          inv_all   = 1'b1;
          fl_done_c = 1'b1;
          nxt       = IDLE;
        end else if (vlds[fl_way] && dtys[fl_way]) begin
          b_wr       = 1'b1;
          b_addr     = {tags[fl_way], fl_set[IDX_W-1:0],
                        {OFF_W{1'b0}}};
          b_data_out = lines[fl_way];
        end
      end
`endif
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      st    <= IDLE;
      vic_q <= '0;
    end else begin
      st <= nxt;
      if (st == IDLE && req && !hit) vic_q <= vic;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int s = 0; s < SETS; s++) rr[s] <= '0;
    end else if (fill_en) begin
      rr[idx] <= (rr[idx] == WAY_W'(WAYS - 1)) ? '0
                                               : rr[idx] + 1'b1;
    end
  end

`ifdef DMEM_FLUSH_EN
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      fl_set <= '0;
      fl_way <= '0;
    end else if (st == IDLE) begin
      fl_set <= '0;
      fl_way <= '0;
    end else if (st == FLUSH && !fl_set[IDX_W]) begin
      if (fl_way == WAY_W'(WAYS - 1)) begin
        fl_way <= '0;
        fl_set <= fl_set + 1'b1;
      end else begin
        fl_way <= fl_way + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_sa.sv
// Directed bench for dmem_sa with bus scoreboard and line-memory model.
// Flush steps are included when DMEM_FLUSH_EN is defined.
module tb_dmem_sa;

  logic         clk;
  logic         clr;
  logic [63:0]  addr;
  logic [2:0]   len;
  logic         rd, wr;
  logic [63:0]  data_in, data_out;
  logic         busy, misalign;
  logic [63:0]  b_addr;
  logic [255:0] b_data_in, b_data_out;
  logic         b_rd, b_dv, b_wr;
`ifdef DMEM_FLUSH_EN
  logic         flush, flush_done;
  int           fd_cnt = 0;
`endif

  int total = 0;
  int bad   = 0;

  logic [255:0] mem [logic [63:0]];
  logic [64:0]  bus_exp[$];
  logic [64:0]  bus_log[$];
  logic [63:0]  ld_q[$];
  bit           auto_dv;
  int           kick_req;
  int           kick_ack;
  bit           pend;
  logic [63:0]  paddr;

  dmem_sa #(
    .LINE_W (256),
    .SETS   (64),
    .WAYS   (2),
    .ADDR_W (64)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .addr       (addr),
    .len        (len),
    .rd         (rd),
    .wr         (wr),
    .data_in    (data_in),
    .data_out   (data_out),
    .busy       (busy),
    .misalign   (misalign),
    .b_addr     (b_addr),
    .b_data_in  (b_data_in),
    .b_rd       (b_rd),
    .b_dv       (b_dv),
    .b_data_out (b_data_out),
    .b_wr       (b_wr)
`ifdef DMEM_FLUSH_EN
    ,
    .flush      (flush),
    .flush_done (flush_done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] pat(input logic [63:0] a);
    logic [255:0] l;
    for (int w = 0; w < 4; w++)
      l[w*64 +: 64] = {a[31:0], 32'h5A00_0000 | 32'(w)};
    return l;
  endfunction

  function automatic logic [255:0] line_of(input logic [63:0] a);
    if (mem.exists(a)) return mem[a];
    return pat(a);
  endfunction

  // bus responder and monitor
  initial begin
    b_dv      = 1'b0;
    b_data_in = '0;
    kick_ack  = 0;
    pend      = 1'b0;
    paddr     = '0;
    forever begin
      @(negedge clk);
      if (b_dv) begin
        b_dv = 1'b0;
      end else if (kick_req != kick_ack) begin
        kick_ack  = kick_req;
        b_data_in = '1;
        b_dv      = 1'b1;
      end else if (pend) begin
        pend      = 1'b0;
        b_data_in = line_of(paddr);
        b_dv      = 1'b1;
      end
      if (b_wr) begin
        bus_log.push_back({1'b1, b_addr});
        mem[b_addr] = b_data_out;
      end
      if (b_rd) begin
        bus_log.push_back({1'b0, b_addr});
        if (auto_dv) begin
          pend  = 1'b1;
          paddr = b_addr;
        end
      end
`ifdef DMEM_FLUSH_EN
      if (flush_done) fd_cnt++;
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_chk(input string tag);
    logic [64:0] e, g;
    while (bus_exp.size() > 0) begin
      e = bus_exp.pop_front();
      g = {1'b1, 64'hDEAD_DEAD_DEAD_DEAD};
      if (bus_log.size() > 0) g = bus_log.pop_front();
      chk({tag, "_bus"}, g, e);
    end
    chk({tag, "_extra"}, bus_log.size(), 0);
    bus_log.delete();
  endtask

  task automatic req(input bit w, input logic [63:0] a,
                     input logic [2:0] l, input logic [63:0] d,
                     output logic [63:0] q, output bit miss);
    @(posedge clk);
    #1;
    rd = !w; wr = w; addr = a; len = l; data_in = d;
    miss = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      miss = 1'b1;
    end
    chk("req_done", busy, 0);
    q = data_out;
    @(posedge clk);
    #1;
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic load(input string tag, input logic [63:0] a,
                      input logic [2:0] l, input logic [63:0] exp,
                      input bit exp_miss);
    logic [63:0] q;
    bit m;
    ld_q.push_back(exp);
    req(1'b0, a, l, 64'd0, q, m);
    chk({tag, "_data"}, q, ld_q.pop_front());
    chk({tag, "_miss"}, m, exp_miss);
  endtask

  task automatic store(input string tag, input logic [63:0] a,
                       input logic [2:0] l, input logic [63:0] d,
                       input bit exp_miss);
    logic [63:0] q;
    bit m;
    req(1'b1, a, l, d, q, m);
    chk({tag, "_miss"}, m, exp_miss);
  endtask

  task automatic mis_req(input string tag, input bit w,
                         input logic [63:0] a, input logic [2:0] l,
                         input logic [63:0] d);
    @(posedge clk);
    #1;
    rd = !w; wr = w; addr = a; len = l; data_in = d;
    @(negedge clk);
    chk({tag, "_mis"}, misalign, 1);
    chk({tag, "_busy"}, busy, 0);
    @(posedge clk);
    #1;
    rd = 1'b0; wr = 1'b0;
  endtask

  initial begin
    clr = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; len = '0;
    data_in = '0; auto_dv = 1'b1; kick_req = 0;
`ifdef DMEM_FLUSH_EN
    flush = 1'b0;
`endif
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_brd", b_rd, 0);
    chk("rst_bwr", b_wr, 0);
    chk("rst_baddr", b_addr, 0);
    chk("rst_bdout", b_data_out, 0);
    chk("rst_dout", data_out, 0);
    rd = 1'b1; addr = 64'h1; len = 3'b010;
    #1;
    chk("rst_mis", misalign, 0);
    rd = 1'b0; addr = '0; len = '0;
    repeat (3) @(posedge clk);
    #1 clr = 1'b0;

    bus_exp.push_back({1'b0, 64'h0});
    store("sb0", 64'h0, 3'b000, 64'hFF, 1'b1);
    bus_chk("sb0");
    load("lb0", 64'h0, 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    load("lbu0", 64'h0, 3'b100, 64'hFF, 1'b0);
    bus_chk("hit0");

    store("sd8", 64'h8, 3'b011, 64'h1122_3344_5566_7788, 1'b0);
    load("ld8", 64'h8, 3'b011, 64'h1122_3344_5566_7788, 1'b0);
    load("lhA", 64'hA, 3'b001, 64'h5566, 1'b0);
    load("lhuE", 64'hE, 3'b101, 64'h1122, 1'b0);
    load("lbF", 64'hF, 3'b000, 64'h11, 1'b0);
    bus_chk("hit8");

    bus_exp.push_back({1'b0, 64'h800});
    load("lw800", 64'h800, 3'b010, 64'h5A00_0000, 1'b1);
    bus_chk("fill800");
    bus_exp.push_back({1'b1, 64'h0});
    bus_exp.push_back({1'b0, 64'h1000});
    load("lw1000", 64'h1000, 3'b010, 64'h5A00_0000, 1'b1);
    bus_chk("evict");
    chk("wb_b0", mem[64'h0][7:0], 8'hFF);
    chk("wb_d8", mem[64'h0][127:64], 64'h1122_3344_5566_7788);
    load("lw804", 64'h804, 3'b010, 64'h800, 1'b0);
    bus_chk("hit800");

    mis_req("mlw", 1'b0, 64'h1002, 3'b010, 64'h0);
    mis_req("msh", 1'b1, 64'h1001, 3'b001, 64'hBEEF);
    mis_req("mld", 1'b0, 64'h1004, 3'b011, 64'h0);
    bus_chk("mis");
    load("ld1000", 64'h1000, 3'b011, 64'h0000_1000_5A00_0000, 1'b0);

    auto_dv = 1'b0;
    bus_exp.push_back({1'b0, 64'h40});
    @(posedge clk);
    #1;
    rd = 1'b1; addr = 64'h40; len = 3'b011;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_log.size() > 0) break;
    end
    @(negedge clk);
    chk("fw_busy", busy, 1);
    chk("fw_brd", b_rd, 0);
    #2 clr = 1'b1;
    #1;
    chk("clr_busy", busy, 0);
    chk("clr_brd", b_rd, 0);
    chk("clr_bwr", b_wr, 0);
    @(posedge clk);
    #1;
    clr = 1'b0; rd = 1'b0;
    kick_req++;
    repeat (4) @(negedge clk);
    bus_chk("clr");
    auto_dv = 1'b1;
    bus_exp.push_back({1'b0, 64'h40});
    load("ld40", 64'h40, 3'b011, 64'h0000_0040_5A00_0000, 1'b1);
    bus_chk("refill40");

`ifdef DMEM_FLUSH_EN
    bus_exp.push_back({1'b0, 64'h0});
    store("sd0f", 64'h0, 3'b011, 64'hAAAA_0000_0000_0001, 1'b1);
    bus_chk("sd0f");
    bus_exp.push_back({1'b0, 64'h800});
    store("sd800f", 64'h800, 3'b011, 64'hBBBB_0000_0000_0002, 1'b1);
    bus_chk("sd800f");
    bus_exp.push_back({1'b1, 64'h0});
    bus_exp.push_back({1'b1, 64'h800});
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("fl_busy", busy, 1);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (fd_cnt > 0) break;
    end
    repeat (2) @(negedge clk);
    chk("fl_done", fd_cnt, 1);
    bus_chk("flush");
    chk("fl_mem0", mem[64'h0][63:0], 64'hAAAA_0000_0000_0001);
    chk("fl_mem800", mem[64'h800][63:0], 64'hBBBB_0000_0000_0002);
    bus_exp.push_back({1'b0, 64'h800});
    load("ld800f", 64'h800, 3'b011, 64'hBBBB_0000_0000_0002, 1'b1);
    bus_chk("post_fl");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
